// File: rtl/mac_pkg.sv
// Shared constants, types and the CRC-32 byte step for the store-and-forward MAC receiver.
package mac_pkg;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam int ERR_CRC   = 0;
  localparam int ERR_RUNT  = 1;
  localparam int ERR_GIANT = 2;
  localparam int ERR_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } rx_state_t;

  // Reflected CRC-32, one byte consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_rx_frame_buf.sv
// Frame buffer with speculative and committed write pointers; uncommitted bytes
// are invisible to the reader and can be dropped by rewinding wr_spec.
module mac_rx_frame_buf
  import mac_pkg::*;
#(
  parameter int BUF_DEPTH = 2048,
  parameter int ADDR_W    = $clog2(BUF_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            wr_last,
  input  logic [7:0]      wr_data,
  input  logic            commit,
  input  logic            rewind,
  input  logic            rd_ready,
  output logic            rd_valid,
  output logic [7:0]      rd_data,
  output logic            rd_last,
  output logic [ADDR_W:0] free
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(BUF_DEPTH);

  logic [8:0]      mem [BUF_DEPTH];
  logic [ADDR_W:0] wr_spec_r;
  logic [ADDR_W:0] wr_com_r;
  logic [ADDR_W:0] rd_r;
  logic [8:0]      rd_word_s;

  // Storage array: each entry is {last, data}.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_spec_r[ADDR_W-1:0]] <= {wr_last, wr_data};
    end
  end

  // Pointer update; a rewind overrides the increment of the same beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_spec_r <= '0;
      wr_com_r  <= '0;
      rd_r      <= '0;
    end else begin
      if (rewind) begin
        wr_spec_r <= wr_com_r;
      end else if (wr_en) begin
        wr_spec_r <= wr_spec_r + PTR_ONE;
      end
      if (commit) begin
        wr_com_r <= wr_spec_r + PTR_ONE;
      end
      if (rd_valid && rd_ready) begin
        rd_r <= rd_r + PTR_ONE;
      end
    end
  end

  assign rd_word_s = mem[rd_r[ADDR_W-1:0]];
  assign rd_valid  = (rd_r != wr_com_r);
  assign rd_data   = rd_word_s[7:0];
  assign rd_last   = rd_word_s[8];
  assign free      = DEPTH_P - (wr_spec_r - rd_r);

endmodule

// File: rtl/mac_rx_sf.sv
// Store-and-forward MAC receiver: CRC/length checks per frame, commits only good
// frames to the output stream, and keeps saturating good/drop statistics.
module mac_rx_sf
  import mac_pkg::*;
#(
  parameter int BUF_DEPTH = 2048,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter int LEN_W     = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             stat_valid,
  output logic [3:0]       stat_err,
  output logic [LEN_W-1:0] stat_len,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_drop
);

  localparam int ADDR_W = $clog2(BUF_DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_SAT  = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  rx_state_t        state_r, state_nxt_s;
  logic [LEN_W-1:0] len_r, len_nxt_s, len_inc_s;
  logic [31:0]      crc_r, crc_nxt_s, crc_upd_s;
  logic [3:0]       err_r, err_nxt_s, fault_s;
  logic             wr_en_s, commit_s, rewind_s, done_s;
  logic [ADDR_W:0]  free_s;

  logic             stat_valid_r;
  logic [3:0]       stat_err_r;
  logic [LEN_W-1:0] stat_len_r;
  logic [CNT_W-1:0] cnt_good_r, cnt_drop_r;

  mac_rx_frame_buf #(
    .BUF_DEPTH (BUF_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en_s),
    .wr_last  (in_last),
    .wr_data  (in_data),
    .commit   (commit_s),
    .rewind   (rewind_s),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rd_data  (out_data),
    .rd_last  (out_last),
    .free     (free_s)
  );

  // Frame-level state, length, CRC and sticky fault register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      len_r   <= '0;
      crc_r   <= CRC_INIT;
      err_r   <= 4'b0000;
    end else begin
      state_r <= state_nxt_s;
      len_r   <= len_nxt_s;
      crc_r   <= crc_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Next-state and buffer control; a fault suppresses the write so a full buffer is never overrun.
  always_comb begin
    state_nxt_s = state_r;
    len_nxt_s   = len_r;
    crc_nxt_s   = crc_r;
    err_nxt_s   = err_r;
    wr_en_s     = 1'b0;
    commit_s    = 1'b0;
    rewind_s    = 1'b0;
    done_s      = 1'b0;
    crc_upd_s   = crc32_byte(crc_r, in_data);
    if (state_r == ST_IDLE) begin
      len_inc_s = LEN_ONE;
    end else if (len_r == LEN_SAT) begin
      len_inc_s = len_r;
    end else begin
      len_inc_s = len_r + LEN_ONE;
    end
    fault_s            = 4'b0000;
    fault_s[ERR_OVF]   = (free_s == '0);
    fault_s[ERR_GIANT] = (len_inc_s > LEN_MAX);

    case (state_r)
      ST_IDLE, ST_RECV: begin
        if (in_valid) begin
          len_nxt_s = len_inc_s;
          if (fault_s != 4'b0000) begin
            rewind_s  = 1'b1;
            err_nxt_s = fault_s;
            crc_nxt_s = CRC_INIT;
            if (in_last) begin
              done_s      = 1'b1;
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_DISCARD;
            end
          end else begin
            wr_en_s             = 1'b1;
            err_nxt_s           = 4'b0000;
            if (in_last) begin
              err_nxt_s[ERR_RUNT] = (len_inc_s < LEN_MIN);
              err_nxt_s[ERR_CRC]  = (crc_upd_s != CRC_RESIDUE);
              done_s              = 1'b1;
              crc_nxt_s           = CRC_INIT;
              state_nxt_s         = ST_IDLE;
              if (err_nxt_s == 4'b0000) begin
                commit_s = 1'b1;
              end else begin
                rewind_s = 1'b1;
              end
            end else begin
              crc_nxt_s   = crc_upd_s;
              state_nxt_s = ST_RECV;
            end
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DISCARD: begin
        if (in_valid) begin
          len_nxt_s = len_inc_s;
          if (in_last) begin
            done_s      = 1'b1;
            crc_nxt_s   = CRC_INIT;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DISCARD;
          end
        end else begin
          state_nxt_s = ST_DISCARD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        crc_nxt_s   = CRC_INIT;
      end
    endcase
  end

  // Per-frame status: pulse the cycle after in_last, hold contents until the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_valid_r <= 1'b0;
      stat_err_r   <= 4'b0000;
      stat_len_r   <= '0;
    end else begin
      stat_valid_r <= done_s;
      if (done_s) begin
        stat_err_r <= err_nxt_s;
        stat_len_r <= len_nxt_s;
      end
    end
  end

  // Saturating statistics; clear has priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_good_r <= '0;
      cnt_drop_r <= '0;
    end else if (cnt_clr) begin
      cnt_good_r <= '0;
      cnt_drop_r <= '0;
    end else if (stat_valid_r) begin
      if (stat_err_r == 4'b0000) begin
        if (cnt_good_r != CNT_SAT) begin
          cnt_good_r <= cnt_good_r + CNT_ONE;
        end
      end else if (cnt_drop_r != CNT_SAT) begin
        cnt_drop_r <= cnt_drop_r + CNT_ONE;
      end
    end
  end

  assign stat_valid = stat_valid_r;
  assign stat_err   = stat_err_r;
  assign stat_len   = stat_len_r;
  assign cnt_good   = cnt_good_r;
  assign cnt_drop   = cnt_drop_r;

endmodule

// File: tb/tb_mac_rx_sf.sv
// Scoreboard bench for mac_rx_sf: instance A uses the default buffer, instance B a
// 128-entry buffer for the overflow case.
module tb_mac_rx_sf;

  localparam logic [31:0] POLY = 32'hEDB8_8320;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_clr = 1'b0;
  always #5 clk = ~clk;

  logic in_valid_a = 1'b0, in_last_a = 1'b0, out_ready_a = 1'b1;
  logic [7:0] in_data_a = 8'h00;
  logic out_valid_a, out_last_a, stat_valid_a;
  logic [7:0] out_data_a;
  logic [3:0] stat_err_a;
  logic [15:0] stat_len_a;
  logic [31:0] cnt_good_a, cnt_drop_a;

  logic in_valid_b = 1'b0, in_last_b = 1'b0, out_ready_b = 1'b0;
  logic [7:0] in_data_b = 8'h00;
  logic out_valid_b, out_last_b, stat_valid_b;
  logic [7:0] out_data_b;
  logic [3:0] stat_err_b;
  logic [15:0] stat_len_b;
  logic [31:0] cnt_good_b, cnt_drop_b;

  mac_rx_sf #(.BUF_DEPTH(2048), .MIN_LEN(64), .MAX_LEN(1518), .LEN_W(16), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_data(in_data_a), .in_last(in_last_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .out_last(out_last_a),
    .stat_valid(stat_valid_a), .stat_err(stat_err_a), .stat_len(stat_len_a),
    .cnt_clr(cnt_clr), .cnt_good(cnt_good_a), .cnt_drop(cnt_drop_a));

  mac_rx_sf #(.BUF_DEPTH(128), .MIN_LEN(64), .MAX_LEN(1518), .LEN_W(16), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_data(in_data_b), .in_last(in_last_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_last(out_last_b),
    .stat_valid(stat_valid_b), .stat_err(stat_err_b), .stat_len(stat_len_b),
    .cnt_clr(cnt_clr), .cnt_good(cnt_good_b), .cnt_drop(cnt_drop_b));

  int n_checks = 0;
  int n_fail = 0;
  logic [19:0] qsa[$], qsb[$];
  logic [8:0]  qba[$], qbb[$];
  logic [7:0]  frm[$];
  logic [19:0] es_a, es_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT produced an item while nothing was expected", name);
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  // Frame of 'total' bytes: deterministic payload followed by a correct FCS.
  task automatic build(input int total, input int seed);
    logic [31:0] crc;
    logic [7:0] b;
    frm.delete();
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < total - 4; i++) begin
      b = 8'(i * 13 + seed);
      frm.push_back(b);
      crc = ref_crc(crc, b);
    end
    crc = ~crc;
    for (int k = 0; k < 4; k++) frm.push_back(crc[8*k +: 8]);
  endtask

  task automatic expect_frame(input bit to_b, input logic [3:0] err, input int len);
    if (to_b) qsb.push_back({err, 16'(len)});
    else      qsa.push_back({err, 16'(len)});
    if (err == 4'b0000) begin
      for (int i = 0; i < frm.size(); i++) begin
        if (to_b) qbb.push_back({(i == frm.size() - 1), frm[i]});
        else      qba.push_back({(i == frm.size() - 1), frm[i]});
      end
    end
  endtask

  task automatic send(input bit to_b, input int count, input bit with_last);
    for (int i = 0; i < count; i++) begin
      @(posedge clk); #1;
      if (to_b) begin
        in_valid_b = 1'b1; in_data_b = frm[i]; in_last_b = with_last && (i == count - 1);
      end else begin
        in_valid_a = 1'b1; in_data_a = frm[i]; in_last_a = with_last && (i == count - 1);
      end
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_last_a = 1'b0; in_valid_b = 1'b0; in_last_b = 1'b0;
    if (with_last) begin
      if (to_b) check("b_stat_timing", 64'(stat_valid_b), 64'd1);
      else      check("a_stat_timing", 64'(stat_valid_a), 64'd1);
    end
  endtask

  task automatic wait_empty(input bit bytes_too, input int budget);
    int t;
    int pend;
    t = 0;
    pend = qsa.size() + qsb.size() + (bytes_too ? qba.size() + qbb.size() : 0);
    while (pend != 0 && t < budget) begin
      @(negedge clk);
      t++;
      pend = qsa.size() + qsb.size() + (bytes_too ? qba.size() + qbb.size() : 0);
    end
    check("drain_pending", 64'(pend), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_cnt(input bit to_b, input int good, input int drop);
    if (to_b) begin
      check("b_cnt_good", 64'(cnt_good_b), 64'(good));
      check("b_cnt_drop", 64'(cnt_drop_b), 64'(drop));
    end else begin
      check("a_cnt_good", 64'(cnt_good_a), 64'(good));
      check("a_cnt_drop", 64'(cnt_drop_a), 64'(drop));
    end
  endtask

  // Monitor for instance A: status and output bytes against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stat_valid_a) begin
        if (qsa.size() == 0) unexpected("a_stat");
        else begin
          es_a = qsa.pop_front();
          check("a_stat_err", 64'(stat_err_a), 64'(es_a[19:16]));
          check("a_stat_len", 64'(stat_len_a), 64'(es_a[15:0]));
          if (es_a[19:16] == 4'b0000) check("a_first_byte_visible", 64'(out_valid_a), 64'd1);
        end
      end
      if (out_valid_a && out_ready_a) begin
        if (qba.size() == 0) unexpected("a_byte");
        else check("a_byte", 64'({out_last_a, out_data_a}), 64'(qba.pop_front()));
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stat_valid_b) begin
        if (qsb.size() == 0) unexpected("b_stat");
        else begin
          es_b = qsb.pop_front();
          check("b_stat_err", 64'(stat_err_b), 64'(es_b[19:16]));
          check("b_stat_len", 64'(stat_len_b), 64'(es_b[15:0]));
          if (es_b[19:16] == 4'b0000) check("b_first_byte_visible", 64'(out_valid_b), 64'd1);
        end
      end
      if (out_valid_b && out_ready_b) begin
        if (qbb.size() == 0) unexpected("b_byte");
        else check("b_byte", 64'({out_last_b, out_data_b}), 64'(qbb.pop_front()));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_stat_valid", 64'(stat_valid_a), 64'd0);
    check("rst_stat_err", 64'(stat_err_a), 64'd0);
    check("rst_stat_len", 64'(stat_len_a), 64'd0);
    check_cnt(1'b0, 0, 0);
    check("rst_out_valid_b", 64'(out_valid_b), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    build(64, 1);   expect_frame(1'b0, 4'b0000, 64);   send(1'b0, 64, 1'b1);
    wait_empty(1'b1, 200);  check_cnt(1'b0, 1, 0);

    build(64, 2);   frm[10] = frm[10] ^ 8'h01;
    expect_frame(1'b0, 4'b0001, 64);  send(1'b0, 64, 1'b1);
    wait_empty(1'b1, 200);  check_cnt(1'b0, 1, 1);

    build(40, 3);   expect_frame(1'b0, 4'b0010, 40);   send(1'b0, 40, 1'b1);
    wait_empty(1'b1, 200);  check_cnt(1'b0, 1, 2);

    build(1519, 4); expect_frame(1'b0, 4'b0100, 1519); send(1'b0, 1519, 1'b1);
    wait_empty(1'b1, 200);
    build(1530, 5); expect_frame(1'b0, 4'b0100, 1530); send(1'b0, 1530, 1'b1);
    wait_empty(1'b1, 200);
    build(64, 6);   expect_frame(1'b0, 4'b0000, 64);   send(1'b0, 64, 1'b1);
    wait_empty(1'b1, 200);  check_cnt(1'b0, 2, 4);

    frm.delete(); frm.push_back(8'h55);
    expect_frame(1'b0, 4'b0011, 1);  send(1'b0, 1, 1'b1);
    wait_empty(1'b1, 200);  check_cnt(1'b0, 2, 5);

    @(posedge clk); #1; cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    @(negedge clk);
    check_cnt(1'b0, 0, 0);

    build(64, 7);   send(1'b0, 20, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_cnt(1'b0, 0, 0);
    check("midrst_out_valid", 64'(out_valid_a), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    build(64, 8);   expect_frame(1'b0, 4'b0000, 64);   send(1'b0, 64, 1'b1);
    wait_empty(1'b1, 200);  check_cnt(1'b0, 1, 0);

    build(64, 9);   expect_frame(1'b1, 4'b0000, 64);   send(1'b1, 64, 1'b1);
    build(100, 10); expect_frame(1'b1, 4'b1000, 100);  send(1'b1, 100, 1'b1);
    wait_empty(1'b0, 200);
    check_cnt(1'b1, 1, 1);
    check("b_hold_valid", 64'(out_valid_b), 64'd1);
    @(posedge clk); #1; out_ready_b = 1'b1;
    wait_empty(1'b1, 400);
    check("b_drained_valid", 64'(out_valid_b), 64'd0);

    check("left_bytes", 64'(qba.size() + qbb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
